// File: rtl/multi_timer_pkg.sv
// Shared register map, CTRL/STAT bit positions and channel state type for multi_timer.
// Optional build macro: MULTI_TIMER_PRESCALER_EN (offset 6 becomes a per-channel prescaler).
package multi_timer_pkg;

    localparam logic [2:0] OFF_B0   = 3'd0;
    localparam logic [2:0] OFF_B1   = 3'd1;
    localparam logic [2:0] OFF_B2   = 3'd2;
    localparam logic [2:0] OFF_B3   = 3'd3;
    localparam logic [2:0] OFF_CTRL = 3'd4;
    localparam logic [2:0] OFF_STAT = 3'd5;
    localparam logic [2:0] OFF_PRE  = 3'd6;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_AUTO = 1;
    localparam int unsigned CTRL_IE   = 2;
    localparam int unsigned STAT_SHOT = 7;

    typedef enum logic {
        ChIdle,
        ChRun
    } chan_state_e;

    // Byte k of a zero-extended counter; bytes beyond the counter width come back as 0.
    function automatic logic [7:0] byte_sel(input logic [31:0] v, input logic [1:0] k);
        return v[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: counter, reload, CTRL bits, sticky shot flag and prescaler.
// Optional build macro: MULTI_TIMER_PRESCALER_EN (without it a tick happens every clk).
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [2:0]       off,
    input  logic [7:0]       wdata,
    output logic [WIDTH-1:0] counter,
    output logic             en,
    output logic             auto_rl,
    output logic             ie,
    output logic             shot,
    output logic [7:0]       pre
);

    localparam int unsigned NB = WIDTH / 8;

    chan_state_e      state_q;
    logic [WIDTH-1:0] counter_q;
    logic [WIDTH-1:0] reload_q;
    logic             auto_q;
    logic             ie_q;
    logic             shot_q;
    logic             tick;
    logic             wr_ctrl;
    logic             wr_stat_clr;
    logic             start;

    assign wr_ctrl     = wr && (off == OFF_CTRL);
    assign wr_stat_clr = wr && (off == OFF_STAT) && wdata[STAT_SHOT];
    assign start       = wr_ctrl && wdata[CTRL_EN] && (state_q == ChIdle);

`ifdef MULTI_TIMER_PRESCALER_EN
    logic [7:0] pre_val_q;
    logic [7:0] pre_cnt_q;

    assign tick = (pre_cnt_q == 8'd0);
    assign pre  = pre_val_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_val_q <= 8'd0;
            pre_cnt_q <= 8'd0;
        end else begin
            if (wr && (off == OFF_PRE)) begin
                pre_val_q <= wdata;
            end
            if (start) begin
                pre_cnt_q <= pre_val_q;
            end else if (state_q == ChRun) begin
                pre_cnt_q <= tick ? pre_val_q : pre_cnt_q - 8'd1;
            end
        end
    end
`else
    assign tick = 1'b1;
    assign pre  = 8'd0;
`endif

    // Reload bytes beyond the counter width do not exist, so writes to them fall away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload_q <= '0;
        end else if (wr && !off[2]) begin
            for (int k = 0; k < NB; k++) begin
                if (off[1:0] == 2'(k)) begin
                    reload_q[8*k +: 8] <= wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ChIdle;
            counter_q <= '0;
            auto_q    <= 1'b0;
            ie_q      <= 1'b0;
            shot_q    <= 1'b0;
        end else begin
            // The expiry assignment further down overrides this clear in the same cycle.
            if (wr_stat_clr) begin
                shot_q <= 1'b0;
            end
            if (wr_ctrl) begin
                auto_q <= wdata[CTRL_AUTO];
                ie_q   <= wdata[CTRL_IE];
            end
            case (state_q)
                ChIdle: begin
                    if (start) begin
                        state_q   <= ChRun;
                        counter_q <= reload_q;
                    end else if (wr_ctrl) begin
                        counter_q <= '0;
                    end
                end
                ChRun: begin
                    if (wr_ctrl && !wdata[CTRL_EN]) begin
                        state_q   <= ChIdle;
                        counter_q <= '0;
                    end else if (tick) begin
                        if (counter_q == '0) begin
                            shot_q <= 1'b1;
                            if (auto_q) begin
                                counter_q <= reload_q;
                            end else begin
                                state_q <= ChIdle;
                            end
                        end else begin
                            counter_q <= counter_q - WIDTH'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign counter = counter_q;
    assign en      = (state_q == ChRun);
    assign auto_rl = auto_q;
    assign ie      = ie_q;
    assign shot    = shot_q;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer: byte-wide register port, per-channel timers, registered read data and irq.
// Optional build macro: MULTI_TIMER_PRESCALER_EN (handled inside timer_channel).
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int unsigned  NCH   = 4,
    parameter int unsigned  WIDTH = 16,
    localparam int unsigned AW    = $clog2(NCH) + 3
) (
    input  logic          clk,
    input  logic          rst,
    output logic [7:0]    dbr,
    input  logic [7:0]    dbw,
    input  logic [AW-1:0] addr,
    input  logic          we,
    output logic          irq
);

    logic [NCH-1:0][WIDTH-1:0] cnt;
    logic [NCH-1:0][7:0]       pre;
    logic [NCH-1:0]            en;
    logic [NCH-1:0]            auto_rl;
    logic [NCH-1:0]            ie;
    logic [NCH-1:0]            shot;
    logic [NCH-1:0]            wr_ch;
    logic [2:0]                off;
    int unsigned               ch_sel;
    logic [7:0]                rdata;

    assign off = addr[2:0];

    // With a single channel the address carries no channel field at all.
    if (AW > 3) begin : g_ch_field
        assign ch_sel = 32'(addr[AW-1:3]);
    end else begin : g_no_ch_field
        assign ch_sel = 32'd0;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign wr_ch[g] = we && (ch_sel == g);

        timer_channel #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .wr      (wr_ch[g]),
            .off     (off),
            .wdata   (dbw),
            .counter (cnt[g]),
            .en      (en[g]),
            .auto_rl (auto_rl[g]),
            .ie      (ie[g]),
            .shot    (shot[g]),
            .pre     (pre[g])
        );
    end

    // Channel indices at or above NCH match no channel and read as 0.
    always_comb begin
        rdata = 8'h00;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (ch_sel == i) begin
                case (off)
                    OFF_B0, OFF_B1, OFF_B2, OFF_B3: rdata = byte_sel(32'(cnt[i]), off[1:0]);
                    OFF_CTRL: begin
                        rdata            = 8'h00;
                        rdata[CTRL_EN]   = en[i];
                        rdata[CTRL_AUTO] = auto_rl[i];
                        rdata[CTRL_IE]   = ie[i];
                    end
                    OFF_STAT: begin
                        rdata            = 8'h00;
                        rdata[STAT_SHOT] = shot[i];
                    end
                    OFF_PRE:  rdata = pre[i];
                    default:  rdata = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbr <= 8'h00;
        end else if (!we) begin
            dbr <= rdata;
        end
    end

    assign irq = |(shot & ie);

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer (NCH=4, WIDTH=16) against a register-level behavioural model.
module tb_multi_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dbr;
    logic [7:0] dbw;
    logic [4:0] addr;
    logic       we;
    logic       irq;

    int passed = 0;
    int total  = 0;

    multi_timer #(
        .NCH   (4),
        .WIDTH (16)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .dbr  (dbr),
        .dbw  (dbw),
        .addr (addr),
        .we   (we),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    // Model state: plain integers per channel, updated once per rising edge.
    int         m_cnt [4];
    int         m_rel [4];
    int         m_pre [4];
    int         m_pcnt[4];
    bit         m_en  [4];
    bit         m_auto[4];
    bit         m_ie  [4];
    bit         m_shot[4];
    logic [7:0] m_dbr;
    logic       m_irq;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_cnt[c] = 0; m_rel[c] = 0; m_pre[c] = 0; m_pcnt[c] = 0;
            m_en[c] = 0; m_auto[c] = 0; m_ie[c] = 0; m_shot[c] = 0;
        end
        m_dbr = 8'h00;
        m_irq = 1'b0;
    endtask

    function automatic logic [7:0] model_read(input int c, input int off);
        case (off)
            0, 1:    return 8'((m_cnt[c] >> (8 * off)) & 255);
            4:       return {5'b0, m_ie[c], m_auto[c], m_en[c]};
            5:       return {m_shot[c], 7'b0};
            6:       return 8'(m_pre[c]);
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step(input logic w, input logic [4:0] ad, input logic [7:0] d);
        int  ch;
        int  off;
        bit  sel;
        bit  expired;
        ch  = int'(ad[4:3]);
        off = int'(ad[2:0]);
        if (!w) m_dbr = model_read(ch, off);
        for (int c = 0; c < 4; c++) begin
            sel     = w && (ch == c);
            expired = 0;
            if (sel && off == 4 && !d[0]) begin
                m_en[c]  = 0;
                m_cnt[c] = 0;
            end else if (sel && off == 4 && !m_en[c]) begin
                m_en[c]   = 1;
                m_cnt[c]  = m_rel[c];
                m_pcnt[c] = m_pre[c];
            end else if (m_en[c]) begin
                if (m_pcnt[c] == 0) begin
                    m_pcnt[c] = m_pre[c];
                    if (m_cnt[c] == 0) begin
                        expired = 1;
                        if (m_auto[c]) m_cnt[c] = m_rel[c];
                        else m_en[c] = 0;
                    end else begin
                        m_cnt[c] = m_cnt[c] - 1;
                    end
                end else begin
                    m_pcnt[c] = m_pcnt[c] - 1;
                end
            end
            if (sel && off == 4) begin
                m_auto[c] = d[1];
                m_ie[c]   = d[2];
            end
            if (sel && off < 2)
                m_rel[c] = (m_rel[c] & ~(32'hFF << (8 * off))) | (int'(d) << (8 * off));
`ifdef MULTI_TIMER_PRESCALER_EN
            if (sel && off == 6) m_pre[c] = int'(d);
`endif
            if (expired) m_shot[c] = 1;
            else if (sel && off == 5 && d[7]) m_shot[c] = 0;
        end
        m_irq = 0;
        for (int c = 0; c < 4; c++) m_irq = m_irq | (m_shot[c] & m_ie[c]);
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst) model_step(we, addr, dbw);
    end

    always @(negedge clk) begin
        check("dbr_vs_model", dbr, m_dbr);
        check("irq_vs_model", {7'b0, irq}, {7'b0, m_irq});
    end

    // Each op occupies exactly one rising edge; inputs change only away from it.
    task automatic op(input logic w, input int ch, input int off, input logic [7:0] d);
        @(negedge clk);
        we   = w;
        addr = 5'(ch * 8 + off);
        dbw  = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic wr(input int ch, input int off, input logic [7:0] d);
        op(1'b1, ch, off, d);
    endtask

    task automatic rd(input int ch, input int off);
        op(1'b0, ch, off, 8'h00);
    endtask

    task automatic rd_chk(input int ch, input int off, input logic [7:0] exp, input string name);
        rd(ch, off);
        check(name, dbr, exp);
    endtask

    task automatic irq_chk(input logic exp, input string name);
        check(name, {7'b0, irq}, {7'b0, exp});
    endtask

    initial begin
        rst  = 1'b1;
        we   = 1'b0;
        addr = '0;
        dbw  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // Reset state
        rd_chk(0, 0, 8'h00, "reset_cnt");
        rd_chk(0, 4, 8'h00, "reset_ctrl");
        rd_chk(3, 5, 8'h00, "reset_stat");
        irq_chk(1'b0, "reset_irq");

        // One-shot countdown: 3,2,1,0 then expiry and self-disable
        wr(0, 0, 8'h03);
        wr(0, 1, 8'h00);
        wr(0, 2, 8'hAA);
        wr(0, 4, 8'h01);
        rd_chk(0, 0, 8'h03, "oneshot_c3");
        rd_chk(0, 0, 8'h02, "oneshot_c2");
        rd_chk(0, 0, 8'h01, "oneshot_c1");
        rd_chk(0, 0, 8'h00, "oneshot_c0");
        rd_chk(0, 5, 8'h80, "oneshot_shot");
        rd_chk(0, 4, 8'h00, "oneshot_en_clr");
        rd_chk(0, 0, 8'h00, "oneshot_stays0");
        rd_chk(0, 2, 8'h00, "byte2_reads0");
        rd_chk(0, 7, 8'h00, "off7_reads0");
        wr(0, 5, 8'h7F);
        rd_chk(0, 5, 8'h80, "stat_nop_write");
        wr(0, 5, 8'h80);
        rd_chk(0, 5, 8'h00, "stat_clear");

        // Auto-reload period 3 with interrupt, clear, and clear colliding with expiry
        wr(1, 0, 8'h02);
        wr(1, 1, 8'h00);
        wr(1, 4, 8'h07);
        rd_chk(1, 0, 8'h02, "auto_c2");
        rd_chk(1, 0, 8'h01, "auto_c1");
        rd_chk(1, 0, 8'h00, "auto_c0");
        irq_chk(1'b1, "auto_irq_first");
        wr(1, 5, 8'h80);
        irq_chk(1'b0, "auto_irq_cleared");
        rd(1, 0);
        irq_chk(1'b0, "auto_irq_still_low");
        rd(1, 0);
        irq_chk(1'b1, "auto_irq_second");
        rd(1, 0);
        rd(1, 0);
        wr(1, 5, 8'h80);
        irq_chk(1'b1, "set_beats_clear_irq");
        rd_chk(1, 5, 8'h80, "set_beats_clear_stat");
        wr(1, 4, 8'h00);
        wr(1, 5, 8'h80);
        irq_chk(1'b0, "stop_irq_low");
        rd_chk(1, 0, 8'h00, "stop_cnt_cleared");

        // Independent channels: ch0 period 6, ch3 period 10; reload rewrite mid-run
        wr(0, 0, 8'h05);
        wr(3, 0, 8'h09);
        wr(3, 1, 8'h00);
        wr(0, 4, 8'h01);
        wr(3, 4, 8'h01);
        rd_chk(1, 0, 8'h00, "ch1_idle");
        wr(3, 0, 8'h02);
        rd_chk(2, 0, 8'h00, "ch2_idle_lo");
        rd_chk(2, 1, 8'h00, "ch2_idle_hi");
        rd_chk(0, 5, 8'h00, "ch0_before_shot");
        rd_chk(0, 5, 8'h80, "ch0_shot");
        rd_chk(3, 0, 8'h03, "ch3_c3");
        rd_chk(3, 0, 8'h02, "ch3_c2");
        rd_chk(3, 0, 8'h01, "ch3_c1");
        rd_chk(3, 5, 8'h00, "ch3_before_shot");
        rd_chk(3, 5, 8'h80, "ch3_shot");
        rd_chk(3, 0, 8'h00, "ch3_stays0");
        wr(3, 4, 8'h01);
        rd_chk(3, 0, 8'h02, "ch3_new_reload");

        // Asynchronous reset mid-count
        wr(2, 0, 8'h34);
        wr(2, 1, 8'h12);
        wr(2, 4, 8'h07);
        rd_chk(2, 0, 8'h34, "ch2_lo_1234");
        rd_chk(2, 1, 8'h12, "ch2_hi_1234");
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_dbr", dbr, 8'h00);
        irq_chk(1'b0, "async_rst_irq");
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        rd_chk(2, 0, 8'h00, "post_rst_lo");
        rd_chk(2, 1, 8'h00, "post_rst_hi");
        rd_chk(2, 4, 8'h00, "post_rst_ctrl");
        rd_chk(3, 4, 8'h00, "post_rst_ctrl3");
        repeat (20) rd(2, 5);
        rd_chk(2, 5, 8'h00, "post_rst_no_shot");
        irq_chk(1'b0, "post_rst_irq");

`ifdef MULTI_TIMER_PRESCALER_EN
        // Prescaler P=3, reload 1: expiry on the 8th edge after enable
        wr(0, 6, 8'h03);
        wr(0, 0, 8'h01);
        wr(0, 1, 8'h00);
        wr(0, 4, 8'h01);
        repeat (7) rd(0, 5);
        rd_chk(0, 5, 8'h00, "pre_before_shot");
        rd_chk(0, 5, 8'h80, "pre_shot");
        rd_chk(0, 6, 8'h03, "pre_readback");
`else
        wr(0, 6, 8'h55);
        rd_chk(0, 6, 8'h00, "off6_reads0");
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL provide parameter NCH, default 4, number of independent timer channels (1..8).
REQ-002 SHALL provide parameter WIDTH, default 16, counter width in bits (multiple of 8, 8..32).
REQ-003 SHALL provide localparam AW = $clog2(NCH)+3, address width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 dbr  output  8  registered read data.
REQ-007 dbw  input  8  write data.
REQ-008 addr  input  AW  addr[AW-1:3] = channel, addr[2:0] = register offset.
REQ-009 we  input  1  1 = write cycle, 0 = read cycle (read performed every non-write cycle).
REQ-010 irq  output  1  level interrupt, OR over channels of (shot & ie).

Function
REQ-011 Offsets 0..3 SHALL be byte k of the channel: write sets reload[8k+7:8k]; read returns counter[8k+7:8k]; bytes k >= WIDTH/8 read 0, writes ignored.
REQ-012 Offset 4 (CTRL) SHALL be {5'b0, ie, auto, en}, read/write.
REQ-013 Offset 5 (STAT) SHALL read {shot, 7'b0}; writing with dbw[7]=1 clears shot; dbw[7]=0 has no effect.
REQ-014 Offsets 6..7 SHALL read 0 and ignore writes unless REQ-027 applies; a channel index >= NCH SHALL read 0 and ignore writes.
REQ-015 dbr SHALL update one cycle after the read address is presented; dbr holds its value during write cycles.
REQ-016 Writing en 0->1 SHALL load counter <= reload in that cycle; no decrement that cycle.
REQ-017 Writing en=0 SHALL stop the channel and clear counter to 0; shot is unchanged.
REQ-018 Per channel states: IDLE (en=0), RUN (en=1); RUN decrements counter by 1 on each tick (every clk without macro).
REQ-019 On a tick with counter==0 in RUN: shot <= 1; if auto=1, counter <= reload and stay RUN; if auto=0, counter stays 0 and en <= 0 (IDLE).
REQ-020 Period SHALL be reload+1 ticks; reload=0 with auto=1 expires every tick.
REQ-021 Writing reload bytes while RUN SHALL NOT alter counter; the new value takes effect at next load or expiry.
REQ-022 Expiry and STAT clear in the same cycle: set wins, shot = 1.
REQ-023 Writing CTRL en=1 while already RUN SHALL NOT reload counter; only auto and ie update.
REQ-024 irq SHALL be combinational from registered shot and ie bits, glitch-free relative to clk.

Reset
REQ-025 On rst: counter, reload, en, auto, ie, shot, prescaler state = 0; dbr = 8'h00; irq = 0.
REQ-026 rst asserted mid-count SHALL abort immediately; no expiry is reported after release.

Configuration
REQ-027 With MULTI_TIMER_PRESCALER_EN defined: offset 6 SHALL be a per-channel 8-bit prescale value P (read/write); a tick occurs every P+1 clk cycles while RUN; the prescale counter reloads from P on en 0->1 and on each tick.
REQ-028 Without MULTI_TIMER_PRESCALER_EN: offset 6 reads 0, ignores writes, and a tick occurs every clk cycle; no prescaler flops are synthesised.

Structure
REQ-029 A package multi_timer_pkg SHALL hold register offset constants (OFF_B0..OFF_B3, OFF_CTRL, OFF_STAT, OFF_PRE) and CTRL/STAT bit positions.
REQ-030 A sub-module timer_channel (one per channel, generated NCH times) SHALL hold counter, reload, control, shot and prescaler; the top SHALL hold the address decode, the read mux, dbr and irq.

Verification
REQ-031 WIDTH=16: write reload 0x0003, CTRL=0x01 -> counter reads 3,2,1,0; shot=1 on the 4th tick; en clears to 0; counter stays 0.
REQ-032 auto=1, reload=2, ie=1 -> shot set and irq high every 3 cycles; STAT write 0x80 drops irq next cycle.
REQ-033 Expiry cycle coincides with STAT write 0x80 -> shot reads 1 afterwards.
REQ-034 NCH=4: run ch0 reload 5 and ch3 reload 9 -> independent shots at cycles 6 and 10; reads of ch1/ch2 counters stay 0.
REQ-035 rst pulse while counter=0x1234 in RUN -> all registers read 0, irq=0, no later shot.
REQ-036 With MULTI_TIMER_PRESCALER_EN, P=3, reload=1 -> shot after 8 clk cycles; without the macro, offset 6 reads 0.
